// File: rtl/multicycle_alu_pkg.sv
// Shared ALU definitions: funct codes and FSM/datapath encodings used by the
// multi-cycle ALU and its iterative multiply/divide datapath.
package alu_pkg;
  localparam logic [5:0] ADD  = 6'd0;
  localparam logic [5:0] ADDI = 6'd1;
  localparam logic [5:0] SUB  = 6'd2;
  localparam logic [5:0] SUBI = 6'd3;
  localparam logic [5:0] AND  = 6'd4;
  localparam logic [5:0] ANDI = 6'd5;
  localparam logic [5:0] OR   = 6'd6;
  localparam logic [5:0] ORI  = 6'd7;
  localparam logic [5:0] XOR  = 6'd8;
  localparam logic [5:0] NOR  = 6'd9;
  localparam logic [5:0] NOT  = 6'd10;
  localparam logic [5:0] SLT  = 6'd11;
  localparam logic [5:0] SLE  = 6'd12;
  localparam logic [5:0] SGT  = 6'd13;
  localparam logic [5:0] SGE  = 6'd14;
  localparam logic [5:0] EQ   = 6'd15;
  localparam logic [5:0] NEQ  = 6'd16;
  localparam logic [5:0] MULT = 6'd17;
  localparam logic [5:0] DIV  = 6'd18;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_e;
  typedef enum logic {MD_MUL, MD_DIV} md_mode_e;
endpackage

// File: rtl/multicycle_alu_if.sv
// Start/busy/done request bus between execute-stage control and the ALU.
interface multicycle_alu_if #(parameter int WIDTH = 32);
  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] RSvalue;
  logic [WIDTH-1:0] RTvalue;
  logic [WIDTH-1:0] immediate;
  logic [WIDTH-1:0] RDvalue;
  logic [WIDTH-1:0] RDhigh;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic             illegal;

  modport master (output start, funct, RSvalue, RTvalue, immediate,
                  input  RDvalue, RDhigh, busy, done, div_by_zero, illegal);
  modport slave  (input  start, funct, RSvalue, RTvalue, immediate,
                  output RDvalue, RDhigh, busy, done, div_by_zero, illegal);
endinterface

// File: rtl/multicycle_alu_iterative_muldiv.sv
// One-bit-per-step shift-add multiplier / restoring divider. hi_o/lo_o show the
// value the current step will register, so the caller can capture the final step directly.
module iterative_muldiv import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  md_mode_e         mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             last_o
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [WIDTH-1:0] hi_step, lo_step;
  logic [WIDTH:0]   sum, shl, diff;
  md_mode_e         mode_q, mode_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // MUL: {hi,lo} shifts right with the carry of hi+b when lo[0]=1.
  // DIV: partial remainder in hi, dividend shifts out of lo while quotient bits shift in.
  always_comb begin
    sum  = {1'b0, hi_q} + {1'b0, b_q};
    shl  = {hi_q, lo_q[WIDTH-1]};
    diff = shl - {1'b0, b_q};
    if (mode_q == MD_MUL) begin
      if (lo_q[0]) {hi_step, lo_step} = {sum, lo_q[WIDTH-1:1]};
      else         {hi_step, lo_step} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      hi_step = diff[WIDTH-1:0];
      lo_step = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      hi_step = shl[WIDTH-1:0];
      lo_step = {lo_q[WIDTH-2:0], 1'b0};
    end
  end

  assign last_o = step_i && (cnt_q == CW'(WIDTH - 1));
  assign hi_o   = hi_step;
  assign lo_o   = lo_step;

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    b_d    = b_q;
    mode_d = mode_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      hi_d   = '0;
      lo_d   = a_i;
      b_d    = b_i;
      mode_d = mode_i;
      cnt_d  = '0;
    end else if (step_i) begin
      hi_d  = hi_step;
      lo_d  = lo_step;
      cnt_d = last_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      mode_q <= MD_MUL;
      cnt_q  <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      b_q    <= b_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/multicycle_alu.sv
// Registered execute-stage ALU: single-cycle ops complete one cycle after start,
// MULT/DIV iterate WIDTH cycles with busy held high.
module multicycle_alu import alu_pkg::*; #(
  parameter int WIDTH      = 32,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  multicycle_alu_if.slave   bus
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] rd_q, rd_d, rdh_q, rdh_d;
  logic             done_q, done_d, dbz_q, dbz_d, ill_q, ill_d;
  logic [WIDTH-1:0] alu_res, md_hi, md_lo;
  logic             md_load, md_step, md_last, lt, eq;
  md_mode_e         md_mode;

  always_comb begin
    lt = SIGNED_CMP ? ($signed(bus.RSvalue) < $signed(bus.RTvalue))
                    : (bus.RSvalue < bus.RTvalue);
    eq = (bus.RSvalue == bus.RTvalue);
    case (bus.funct)
      ADD:     alu_res = bus.RSvalue + bus.RTvalue;
      ADDI:    alu_res = bus.RSvalue + bus.immediate;
      SUB:     alu_res = bus.RSvalue - bus.RTvalue;
      SUBI:    alu_res = bus.RSvalue - bus.immediate;
      AND:     alu_res = bus.RSvalue & bus.RTvalue;
      ANDI:    alu_res = bus.RSvalue & bus.immediate;
      OR:      alu_res = bus.RSvalue | bus.RTvalue;
      ORI:     alu_res = bus.RSvalue | bus.immediate;
      XOR:     alu_res = bus.RSvalue ^ bus.RTvalue;
      NOR:     alu_res = ~(bus.RSvalue | bus.RTvalue);
      NOT:     alu_res = ~bus.RSvalue;
      SLT:     alu_res = {{(WIDTH-1){1'b0}}, lt};
      SLE:     alu_res = {{(WIDTH-1){1'b0}}, lt | eq};
      SGT:     alu_res = {{(WIDTH-1){1'b0}}, ~(lt | eq)};
      SGE:     alu_res = {{(WIDTH-1){1'b0}}, ~lt};
      EQ:      alu_res = {{(WIDTH-1){1'b0}}, eq};
      NEQ:     alu_res = {{(WIDTH-1){1'b0}}, ~eq};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    rdh_d   = rdh_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    ill_d   = 1'b0;
    md_load = 1'b0;
    md_step = 1'b0;
    md_mode = MD_MUL;
    case (state_q)
      ST_IDLE: if (bus.start) begin
        if (bus.funct == MULT) begin
          md_load = 1'b1;
          state_d = ST_MUL;
        end else if (bus.funct == DIV) begin
          md_mode = MD_DIV;
          // Divide by zero short-circuits: no iterations, fixed result.
          if (bus.RTvalue == '0) begin
            done_d = 1'b1;
            dbz_d  = 1'b1;
            rd_d   = '1;
            rdh_d  = bus.RSvalue;
          end else begin
            md_load = 1'b1;
            state_d = ST_DIV;
          end
        end else begin
          done_d = 1'b1;
          ill_d  = (bus.funct > DIV);
          rd_d   = alu_res;
          rdh_d  = '0;
        end
      end
      ST_MUL, ST_DIV: begin
        md_step = 1'b1;
        if (md_last) begin
          rd_d    = md_lo;
          rdh_d   = md_hi;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rd_q    <= '0;
      rdh_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      rdh_q   <= rdh_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      ill_q   <= ill_d;
    end
  end

  iterative_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clock),
    .rst    (reset),
    .load_i (md_load),
    .step_i (md_step),
    .mode_i (md_mode),
    .a_i    (bus.RSvalue),
    .b_i    (bus.RTvalue),
    .hi_o   (md_hi),
    .lo_o   (md_lo),
    .last_o (md_last)
  );

  assign bus.RDvalue     = rd_q;
  assign bus.RDhigh      = rdh_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.illegal     = ill_q;
endmodule
